dbc_port_status_tracker: RTL and testbench
==========================================

# dbc_port_status_tracker

Upstream feeder of the DbC port state machine. It debounces the raw connect line, tracks port-enabled and link state, and produces the sticky change bits CSC, PRC, PLC and CEC, together with CCS and PED, that the port state machine consumes. Software clears the change bits with write-1-to-clear strobes. A request/acknowledge handshake raises one Port Status Change event toward the event-ring logic each time the OR of the change bits goes from 0 to 1.

## Interface
- DEBOUNCE_CYCLES, 16: number of consecutive cycles raw_connect must differ from CCS before CCS updates; legal range 1..255.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- DCE  input  1  DbC enable; while 0 the block is held at reset values.
- raw_connect  input  1  connect indication from the PHY, already synchronised to clock.
- link_state  input  4  port link state from the link layer; 4'h0 = U0, 4'h6 = Inactive.
- port_reset_done  input  1  one-cycle pulse when the link finishes a port reset.
- config_error  input  1  one-cycle pulse when link configuration fails.
- wr_clr  input  4  write-1-to-clear strobes, one per change bit: bit0 CSC, bit1 PRC, bit2 PLC, bit3 CEC.
- evt_ack  input  1  event-ring logic accepted the event.
- CCS  output  1  debounced current connect status.
- PED  output  1  port enabled.
- PLS  output  4  registered link_state.
- CSC, PRC, PLC, CEC  output  1 each  sticky change bits.
- evt_req  output  1  Port Status Change event request.

## Operation
- Reset values: all outputs 0, debounce counter 0, event FSM in IDLE. The same values apply while DCE=0, and all other inputs are ignored during that time.
- Debounce (8-bit counter cnt):
  - If raw_connect==CCS: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: CCS<=raw_connect, cnt<=0, CSC<=1.
  - Else: cnt<=cnt+1.
  - Any single-cycle return of raw_connect to equal CCS restarts the count.
- PED and its change bits:
  - PED is set, and PRC is set, on port_reset_done while CCS=1. port_reset_done while CCS=0 is ignored.
  - PED is cleared when CCS falls. This clear happens in the same cycle CCS updates to 0; no change bit is set by this clear beyond CSC.
  - PED is cleared, and CEC is set, on config_error while PED=1.
  - PED is cleared when PLS becomes 4'h6.
- PLS and PLC:
  - PLS<=link_state every cycle.
  - PLC<=1 when link_state!=PLS and PED=1, evaluated on the pre-update PED value.
- Clear priority: for each change bit, a set condition in a cycle beats the wr_clr strobe for that bit in the same cycle. CCS, PED and PLS are not software-writable.
- Event FSM (any = CSC|PRC|PLC|CEC, registered values):
  - IDLE: if any=1, go to REQ.
  - REQ: evt_req=1; when evt_ack=1, go to WAIT_CLR.
  - WAIT_CLR: evt_req=0; when any=0, go to IDLE.
  - Result: exactly one event per 0->1 edge of any. New change bits set while in REQ or WAIT_CLR do not create extra events.
  - DCE=0 or reset returns the FSM to IDLE and drops evt_req at once.

## Timing
- All outputs are registered. The change bits, CCS, PED and PLS update on the clock edge after their qualifying input.
- Connect latency: CCS and CSC change on the DEBOUNCE_CYCLES-th consecutive rising edge that samples raw_connect!=CCS.
- evt_req rises one cycle after any becomes 1 and stays high until the edge that samples evt_ack=1. It falls on that edge.
- evt_ack while evt_req=0 is ignored.
- Reset or DCE=0 in mid-debounce or mid-handshake: the next cycle shows all outputs at 0 with no partial event.

## Test plan
- DEBOUNCE_CYCLES=4; raw_connect 0->1 held -> CCS=1 and CSC=1 on the 4th edge; evt_req=1 on the following edge.
- raw_connect high for 3 cycles, low for 1, then high for 4 -> CCS stays 0 until the 4th edge of the second run; exactly one CSC set.
- CCS=1, port_reset_done pulse -> PED=1, PRC=1 next cycle. Then link_state 0->6 -> PLS=6, PLC=1, PED=0. wr_clr=4'b0110 -> PRC=0, PLC=0.
- CSC=1 with evt_req=1; hold evt_ack=0 for 5 cycles -> evt_req stays 1. evt_ack=1 -> evt_req=0. config_error while PED=1 -> CEC=1 and no new evt_req until all bits are cleared and then set again.
- Same-cycle CSC set and wr_clr[0]=1 -> CSC=1.
- DCE dropped to 0 during REQ with PED=1 -> next cycle all outputs are 0. DCE back to 1 with raw_connect=1 -> a fresh debounce of 4 cycles occurs.

Source files
------------

// File: rtl/dbc_port_status_tracker_if.sv
// Signal bundle between the DbC port status tracker and its link/software side.
// The tracker uses the slave modport; the driving environment uses master.
interface dbc_port_status_tracker_if;
  logic       DCE;
  logic       raw_connect;
  logic [3:0] link_state;
  logic       port_reset_done;
  logic       config_error;
  logic [3:0] wr_clr;
  logic       evt_ack;
  logic       CCS;
  logic       PED;
  logic [3:0] PLS;
  logic       CSC;
  logic       PRC;
  logic       PLC;
  logic       CEC;
  logic       evt_req;

  modport master (
    output DCE, raw_connect, link_state, port_reset_done, config_error, wr_clr, evt_ack,
    input  CCS, PED, PLS, CSC, PRC, PLC, CEC, evt_req
  );

  modport slave (
    input  DCE, raw_connect, link_state, port_reset_done, config_error, wr_clr, evt_ack,
    output CCS, PED, PLS, CSC, PRC, PLC, CEC, evt_req
  );
endinterface

// File: rtl/dbc_port_status_tracker.sv
// Debounces connect, tracks port enable and link state, keeps the sticky change
// bits and raises one Port Status Change event per 0->1 edge of their OR.
module dbc_port_status_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                      clock,
  input logic                      reset,
  dbc_port_status_tracker_if.slave port
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LS_INACTIVE = 4'h6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_CLR
  } evt_state_t;

  evt_state_t state;
  logic [7:0] cnt;
  logic       ccs, ped, csc, prc, plc, cec, evt_req;
  logic [3:0] pls;

  logic deb_done, ccs_fall, csc_set, prc_set, plc_set, cec_set, ped_next, any;

  always_comb begin
    deb_done = (port.raw_connect != ccs) && (cnt == CNT_LAST);
    ccs_fall = deb_done && ccs;
    csc_set  = deb_done;
    prc_set  = port.port_reset_done && ccs;
    cec_set  = port.config_error && ped;
    plc_set  = (port.link_state != pls) && ped;
    any      = csc | prc | plc | cec;
    // Clears are applied after the set so a falling link or connect wins.
    ped_next = ped;
    if (prc_set) ped_next = 1'b1;
    if (cec_set || ccs_fall || (port.link_state == LS_INACTIVE)) ped_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset || !port.DCE) begin
      state   <= IDLE;
      cnt     <= '0;
      ccs     <= 1'b0;
      ped     <= 1'b0;
      pls     <= '0;
      csc     <= 1'b0;
      prc     <= 1'b0;
      plc     <= 1'b0;
      cec     <= 1'b0;
      evt_req <= 1'b0;
    end else begin
      if (port.raw_connect == ccs) begin
        cnt <= '0;
      end else if (deb_done) begin
        ccs <= port.raw_connect;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end

      ped <= ped_next;
      pls <= port.link_state;

      csc <= csc_set | (csc & ~port.wr_clr[0]);
      prc <= prc_set | (prc & ~port.wr_clr[1]);
      plc <= plc_set | (plc & ~port.wr_clr[2]);
      cec <= cec_set | (cec & ~port.wr_clr[3]);

      case (state)
        IDLE: begin
          if (any) begin
            state   <= REQ;
            evt_req <= 1'b1;
          end
        end
        REQ: begin
          if (port.evt_ack) begin
            state   <= WAIT_CLR;
            evt_req <= 1'b0;
          end
        end
        WAIT_CLR: begin
          evt_req <= 1'b0;
          if (!any) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          evt_req <= 1'b0;
        end
      endcase
    end
  end

  assign port.CCS     = ccs;
  assign port.PED     = ped;
  assign port.PLS     = pls;
  assign port.CSC     = csc;
  assign port.PRC     = prc;
  assign port.PLC     = plc;
  assign port.CEC     = cec;
  assign port.evt_req = evt_req;

endmodule

// File: tb/tb_dbc_port_status_tracker.sv
// Directed bench for the DbC port status tracker with a 4-cycle debounce.
module tb_dbc_port_status_tracker;

  logic clock;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_bad;

  dbc_port_status_tracker_if bus ();

  dbc_port_status_tracker #(.DEBOUNCE_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .port  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected vector layout: CCS PED PLS[3:0] CSC PRC PLC CEC evt_req
  function automatic logic [10:0] ev(input logic ccs, input logic ped, input logic [3:0] pls,
                                     input logic csc, input logic prc, input logic plc,
                                     input logic cec, input logic req);
    return {ccs, ped, pls, csc, prc, plc, cec, req};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {bus.CCS, bus.PED, bus.PLS, bus.CSC, bus.PRC, bus.PLC, bus.CEC, bus.evt_req};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.DCE = 1'b0;
    bus.raw_connect = 1'b0;
    bus.link_state = 4'h0;
    bus.port_reset_done = 1'b0;
    bus.config_error = 1'b0;
    bus.wr_clr = 4'b0000;
    bus.evt_ack = 1'b0;

    tick(); tick();
    chk("reset", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    bus.DCE = 1'b1;
    tick();
    chk("idle_after_reset", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));

    // Glitch after 3 cycles restarts the debounce.
    bus.raw_connect = 1'b1;
    tick(); tick(); tick();
    chk("deb_3_high", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    bus.raw_connect = 1'b0;
    tick();
    chk("deb_glitch", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    bus.raw_connect = 1'b1;
    tick(); tick(); tick();
    chk("deb_rerun_3", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("deb_connect_4th", ev(1, 0, 4'h0, 1, 0, 0, 0, 0));
    tick();
    chk("evt_req_rise", ev(1, 0, 4'h0, 1, 0, 0, 0, 1));

    // Request holds without acknowledge.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("evt_req_hold", ev(1, 0, 4'h0, 1, 0, 0, 0, 1));
    end
    bus.evt_ack = 1'b1;
    tick();
    chk("evt_ack_drop", ev(1, 0, 4'h0, 1, 0, 0, 0, 0));
    bus.evt_ack = 1'b0;

    bus.port_reset_done = 1'b1;
    tick();
    chk("port_reset_ped", ev(1, 1, 4'h0, 1, 1, 0, 0, 0));
    bus.port_reset_done = 1'b0;
    bus.link_state = 4'h6;
    tick();
    chk("link_inactive", ev(1, 0, 4'h6, 1, 1, 1, 0, 0));
    bus.wr_clr = 4'b0110;
    tick();
    chk("clr_prc_plc", ev(1, 0, 4'h6, 1, 0, 0, 0, 0));
    bus.wr_clr = 4'b0000;
    bus.link_state = 4'h0;
    tick();
    chk("link_change_ped0", ev(1, 0, 4'h0, 1, 0, 0, 0, 0));
    bus.port_reset_done = 1'b1;
    tick();
    chk("port_reset_again", ev(1, 1, 4'h0, 1, 1, 0, 0, 0));
    bus.port_reset_done = 1'b0;
    bus.config_error = 1'b1;
    tick();
    chk("config_error", ev(1, 0, 4'h0, 1, 1, 0, 1, 0));
    bus.config_error = 1'b0;
    tick();
    chk("no_extra_evt", ev(1, 0, 4'h0, 1, 1, 0, 1, 0));
    bus.wr_clr = 4'b1111;
    tick();
    chk("clr_all", ev(1, 0, 4'h0, 0, 0, 0, 0, 0));
    bus.wr_clr = 4'b0000;
    tick();
    chk("back_idle", ev(1, 0, 4'h0, 0, 0, 0, 0, 0));
    bus.port_reset_done = 1'b1;
    tick();
    chk("prc_set_again", ev(1, 1, 4'h0, 0, 1, 0, 0, 0));
    bus.port_reset_done = 1'b0;
    tick();
    chk("new_evt_req", ev(1, 1, 4'h0, 0, 1, 0, 0, 1));

    // Disconnect completes in the same cycle as a CSC clear strobe.
    bus.raw_connect = 1'b0;
    tick(); tick(); tick();
    chk("disc_3", ev(1, 1, 4'h0, 0, 1, 0, 0, 1));
    bus.wr_clr = 4'b0001;
    tick();
    chk("csc_set_beats_clr", ev(0, 0, 4'h0, 1, 1, 0, 0, 1));
    bus.wr_clr = 4'b0000;

    bus.raw_connect = 1'b1;
    tick(); tick(); tick(); tick();
    chk("reconnect", ev(1, 0, 4'h0, 1, 1, 0, 0, 1));
    bus.port_reset_done = 1'b1;
    tick();
    chk("ped_in_req", ev(1, 1, 4'h0, 1, 1, 0, 0, 1));
    bus.port_reset_done = 1'b0;
    bus.DCE = 1'b0;
    bus.link_state = 4'h5;
    tick();
    chk("dce_off", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    bus.link_state = 4'h0;
    bus.DCE = 1'b1;
    tick();
    chk("dce_on_1", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick(); tick();
    chk("dce_on_3", ev(0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("dce_on_4", ev(1, 0, 4'h0, 1, 0, 0, 0, 0));
    tick();
    chk("dce_on_evt", ev(1, 0, 4'h0, 1, 0, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
